// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and default sizing for the load-use hazard scoreboard.
package hazard_scoreboard_pkg;

    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_NUM_SRC  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        TAKE  = 2'd2
    } state_t;

endpackage

// File: rtl/hazard_scoreboard_sb_regfile.sv
// Pending-load bit array: one bit per architectural register, set wins over
// clear on the same address, register 0 can never become pending.
module sb_regfile
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                i_set_en,
    input  logic [AW-1:0]       i_set_addr,
    input  logic                i_clr_en,
    input  logic [AW-1:0]       i_clr_addr,
    output logic [NUM_REGS-1:0] o_pending,
    output logic                o_empty
);

    logic [NUM_REGS-1:0] r_pending;

    // Clear first, then set, so a same-cycle set on the same bit wins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pending <= '0;
        end else begin
            if (i_clr_en) begin
                r_pending[i_clr_addr] <= 1'b0;
            end
            if (i_set_en && (i_set_addr != '0)) begin
                r_pending[i_set_addr] <= 1'b1;
            end
        end
    end

    assign o_pending = r_pending;
    assign o_empty   = (r_pending == '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order pipeline hazard unit: stalls ID on loads still in flight and
// sequences interrupt entry once every outstanding load has written back.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_SRC  = DEF_NUM_SRC,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  id_valid,
    input  logic [NUM_SRC*AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]    id_rs_used,
    input  logic [AW-1:0]         id_rd,
    input  logic                  id_rd_we,
    input  logic                  id_is_load,
    input  logic                  ex_redirect,
    input  logic                  int_req,
    input  logic                  wb_valid,
    input  logic [AW-1:0]         wb_rd,
    output logic                  stall,
    output logic                  pc_write,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  int_ack,
    output logic                  sb_empty
);

    state_t              r_state;
    logic [NUM_REGS-1:0] w_pending;
    logic                w_empty;
    logic                w_raw;
    logic                w_waw;
    logic                w_hazard;
    logic                w_issue;
    logic                w_set_en;
    logic                w_clr_en;

    // A writeback landing this cycle bypasses the hazard on that register.
    always_comb begin
        w_raw = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (id_rs_used[k] && w_pending[id_rs[k*AW +: AW]] &&
                !(wb_valid && (wb_rd == id_rs[k*AW +: AW]))) begin
                w_raw = 1'b1;
            end
        end
    end

    assign w_waw    = id_rd_we && (id_rd != '0) && w_pending[id_rd] &&
                      !(wb_valid && (wb_rd == id_rd));
    assign w_hazard = id_valid && (w_raw || w_waw);

    always_comb begin
        stall       = 1'b0;
        pc_write    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        int_ack     = 1'b0;
        if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (r_state == DRAIN) begin
            stall       = 1'b1;
            pc_write    = 1'b0;
            id_ex_flush = 1'b1;
        end else if (r_state == TAKE) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            int_ack     = 1'b1;
        end else if (w_hazard) begin
            stall       = 1'b1;
            pc_write    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    assign w_issue  = id_valid && !stall && !if_id_flush;
    assign w_set_en = w_issue && id_rd_we && id_is_load && (id_rd != '0);
    assign w_clr_en = wb_valid && (wb_rd != '0);
    assign sb_empty = w_empty;

    // Once DRAIN is entered the interrupt is committed, even if int_req drops.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else if (!ex_redirect) begin
            case (r_state)
                IDLE:    if (int_req) r_state <= DRAIN;
                DRAIN:   if (w_empty) r_state <= TAKE;
                TAKE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    sb_regfile #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_sb_regfile (
        .clk        (clk),
        .rstn       (rstn),
        .i_set_en   (w_set_en),
        .i_set_addr (id_rd),
        .i_clr_en   (w_clr_en),
        .i_clr_addr (wb_rd),
        .o_pending  (w_pending),
        .o_empty    (w_empty)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed scenarios followed by
// randomized traffic, all checked against a set-of-pending-loads model.
module tb_hazard_scoreboard;

    localparam int NREG = 32;
    localparam int NSRC = 2;
    localparam int AW   = 5;

    localparam int MODE_RUN  = 0;
    localparam int MODE_WAIT = 1;
    localparam int MODE_ACK  = 2;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 id_valid;
    logic [NSRC*AW-1:0]   id_rs;
    logic [NSRC-1:0]      id_rs_used;
    logic [AW-1:0]        id_rd;
    logic                 id_rd_we;
    logic                 id_is_load;
    logic                 ex_redirect;
    logic                 int_req;
    logic                 wb_valid;
    logic [AW-1:0]        wb_rd;
    logic                 stall;
    logic                 pc_write;
    logic                 if_id_flush;
    logic                 id_ex_flush;
    logic                 int_ack;
    logic                 sb_empty;

    typedef struct {
        logic [5:0] outs;
        string      tag;
        int         cyc;
    } expect_t;

    expect_t expQ[$];
    int      testsRun    = 0;
    int      testsFailed = 0;
    int      cycleNo     = 0;

    bit modelPend[NREG];
    int modelMode;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NUM_REGS (NREG),
        .NUM_SRC  (NSRC)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rs_used  (id_rs_used),
        .id_rd       (id_rd),
        .id_rd_we    (id_rd_we),
        .id_is_load  (id_is_load),
        .ex_redirect (ex_redirect),
        .int_req     (int_req),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .stall       (stall),
        .pc_write    (pc_write),
        .if_id_flush (if_id_flush),
        .id_ex_flush (id_ex_flush),
        .int_ack     (int_ack),
        .sb_empty    (sb_empty)
    );

    task automatic checkOutput(input expect_t e, input logic [5:0] got);
        testsRun++;
        if (got !== e.outs) begin
            testsFailed++;
            $display("[TB] FAIL %s cycle %0d: {stall,pc_write,if_id_flush,id_ex_flush,int_ack,sb_empty} got %b expected %b",
                     e.tag, e.cyc, got, e.outs);
        end
    endtask

    // Monitor: outputs are combinational, so compare mid-cycle on the falling edge.
    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e, {stall, pc_write, if_id_flush, id_ex_flush, int_ack, sb_empty});
            end
        end
    end

    // One cycle of stimulus; called just after a rising edge.
    task automatic applyStimulus(input bit rstnV, input bit v, input logic [AW-1:0] rs0,
                                 input logic [AW-1:0] rs1, input logic [1:0] used,
                                 input logic [AW-1:0] rd, input bit we, input bit ld,
                                 input bit redir, input bit irq, input bit wbv,
                                 input logic [AW-1:0] wbrd, input string tag);
        bit      anyPend;
        bit      raw;
        bit      waw;
        bit      eStall, ePc, eIfid, eIdex, eAck;
        bit      issue;
        bit      nextPend[NREG];
        int      nextMode;
        logic [AW-1:0] srcs[2];
        expect_t e;

        rstn        = rstnV;
        id_valid    = v;
        id_rs       = {rs1, rs0};
        id_rs_used  = used;
        id_rd       = rd;
        id_rd_we    = we;
        id_is_load  = ld;
        ex_redirect = redir;
        int_req     = irq;
        wb_valid    = wbv;
        wb_rd       = wbrd;

        if (!rstnV) begin
            foreach (modelPend[i]) modelPend[i] = 1'b0;
            modelMode = MODE_RUN;
        end

        anyPend = 1'b0;
        foreach (modelPend[i]) if (modelPend[i]) anyPend = 1'b1;

        srcs[0] = rs0;
        srcs[1] = rs1;
        raw = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (used[k] && modelPend[srcs[k]] && !(wbv && wbrd == srcs[k])) raw = 1'b1;
        end
        waw = we && rd != 0 && modelPend[rd] && !(wbv && wbrd == rd);

        eStall = 0; ePc = 1; eIfid = 0; eIdex = 0; eAck = 0;
        if (redir) begin
            eIfid = 1; eIdex = 1;
        end else if (modelMode == MODE_WAIT) begin
            eStall = 1; ePc = 0; eIdex = 1;
        end else if (modelMode == MODE_ACK) begin
            eIfid = 1; eIdex = 1; eAck = 1;
        end else if (v && (raw || waw)) begin
            eStall = 1; ePc = 0; eIdex = 1;
        end

        e.outs = {eStall, ePc, eIfid, eIdex, eAck, !anyPend};
        e.tag  = tag;
        e.cyc  = cycleNo;
        expQ.push_back(e);

        issue    = v && !eStall && !eIfid;
        nextPend = modelPend;
        if (wbv && wbrd != 0) nextPend[wbrd] = 1'b0;
        if (issue && we && ld && rd != 0) nextPend[rd] = 1'b1;

        nextMode = modelMode;
        if (!redir) begin
            if (modelMode == MODE_RUN && irq) nextMode = MODE_WAIT;
            else if (modelMode == MODE_WAIT && !anyPend) nextMode = MODE_ACK;
            else if (modelMode == MODE_ACK) nextMode = MODE_RUN;
        end

        @(posedge clk);
        #1;
        cycleNo++;
        if (rstnV) begin
            modelPend = nextPend;
            modelMode = nextMode;
        end
    endtask

    task automatic idle(input string tag);
        applyStimulus(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    task automatic issueLoad(input logic [AW-1:0] rd, input string tag);
        applyStimulus(1, 1, 0, 0, 2'b00, rd, 1, 1, 0, 0, 0, 0, tag);
    endtask

    task automatic readReg(input logic [AW-1:0] rs, input string tag);
        applyStimulus(1, 1, rs, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    task automatic writeBack(input logic [AW-1:0] rd, input string tag);
        applyStimulus(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, rd, tag);
    endtask

    initial begin
        int waitCycles;
        rstn = 0; id_valid = 0; id_rs = '0; id_rs_used = '0; id_rd = '0;
        id_rd_we = 0; id_is_load = 0; ex_redirect = 0; int_req = 0;
        wb_valid = 0; wb_rd = '0;
        foreach (modelPend[i]) modelPend[i] = 1'b0;
        modelMode = MODE_RUN;
        @(posedge clk);
        #1;

        applyStimulus(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, "reset");
        idle("post_reset");

        issueLoad(5, "load_x5");
        repeat (3) readReg(5, "raw_x5_stall");
        applyStimulus(1, 1, 5, 0, 2'b01, 0, 0, 0, 0, 0, 1, 5, "raw_x5_bypass");
        idle("after_x5");

        issueLoad(0, "load_x0");
        readReg(0, "read_x0");

        issueLoad(7, "load_x7");
        applyStimulus(1, 1, 0, 0, 2'b00, 7, 1, 1, 0, 0, 1, 7, "x7_set_wins");
        readReg(7, "x7_still_pending");
        writeBack(7, "wb_x7");
        readReg(7, "x7_free");

        issueLoad(3, "load_x3");
        applyStimulus(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, "int_req");
        repeat (2) idle("drain_wait");
        writeBack(3, "drain_wb_x3");
        repeat (4) idle("drain_take_idle");

        issueLoad(9, "load_x9");
        applyStimulus(1, 1, 9, 0, 2'b01, 0, 0, 0, 1, 0, 0, 0, "redirect_over_raw");
        readReg(9, "x9_after_redirect");
        writeBack(9, "wb_x9");

        issueLoad(1, "load_x1");
        issueLoad(2, "load_x2");
        issueLoad(4, "load_x4");
        issueLoad(6, "load_x6");
        applyStimulus(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, "int_req_4pend");
        idle("drain_4pend");
        applyStimulus(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, "reset_in_drain");
        applyStimulus(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, "reset_held");
        repeat (3) idle("after_drain_reset");

        for (int n = 0; n < 3000; n++) begin
            applyStimulus(($urandom_range(0, 199) != 0),
                          ($urandom_range(0, 3) != 0),
                          AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                          2'($urandom_range(0, 3)),
                          AW'($urandom_range(0, 7)),
                          ($urandom_range(0, 1) != 0),
                          ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 11) == 0),
                          ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 2) == 0),
                          AW'($urandom_range(0, 7)),
                          "random");
        end

        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 20) begin
            @(posedge clk);
            waitCycles++;
        end
        if (expQ.size() > 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL drain_queue: %0d entries left, expected 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
